// File: rtl/tdc_multi_echo_capture.sv
// Multi-channel TDC rise/fall capture.
// Accumulates per-channel rising and falling TDC hits within one laser shot.
// On each laser start edge it publishes per-channel rise, fall, pulse width and hit counts.
// The edge cycle snapshots the pre-edge accumulators, and the outputs load one clock later.
module tdc_multi_echo_capture #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_ID_W   = 3,
  parameter int unsigned TDC_W     = 19,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TIMEOUT   = 500000000,
  parameter int unsigned ERR_LIMIT = 2000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_laser_str,
  input  logic [1:0]                i_sel_mode,
  input  logic                      i_tdc_result_edge_id,
  input  logic [CH_ID_W-1:0]        i_tdc_result_channel_id,
  input  logic                      i_tdc_result_valid_flag,
  input  logic [TDC_W-1:0]          i_tdc_result,
  output logic [NUM_CH*DATA_W-1:0]  o_rise_data,
  output logic [NUM_CH*DATA_W-1:0]  o_fall_data,
  output logic [NUM_CH*DATA_W-1:0]  o_pulse_width,
  output logic [NUM_CH*CNT_W-1:0]   o_rise_cnt,
  output logic [NUM_CH*CNT_W-1:0]   o_fall_cnt,
  output logic                      o_data_valid,
  output logic                      o_err_flag,
  output logic                      o_armed
);

  localparam int unsigned       TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_LIM  = DATA_W'(ERR_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CH_ID_W:0]  CH_LIMIT = (CH_ID_W + 1)'(NUM_CH);

  logic              laser_q;
  logic              shot_edge;
  logic              publish;
  logic [TO_W-1:0]   to_cnt_q;
  logic              armed_q;

  logic              hit_ok;
  logic [DATA_W-1:0] hit_val;

  logic [DATA_W-1:0] rise_acc_q [NUM_CH];
  logic [DATA_W-1:0] rise_acc_d [NUM_CH];
  logic [DATA_W-1:0] fall_acc_q [NUM_CH];
  logic [DATA_W-1:0] fall_acc_d [NUM_CH];
  logic [CNT_W-1:0]  rise_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  rise_cnt_d [NUM_CH];
  logic [CNT_W-1:0]  fall_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  fall_cnt_d [NUM_CH];

  logic              pend_q;
  logic [DATA_W-1:0] snap_rise_q [NUM_CH];
  logic [DATA_W-1:0] snap_fall_q [NUM_CH];
  logic [CNT_W-1:0]  snap_rcnt_q [NUM_CH];
  logic [CNT_W-1:0]  snap_fcnt_q [NUM_CH];
  logic [DATA_W-1:0] pw_next     [NUM_CH];
  logic              err_any;

  logic [NUM_CH*DATA_W-1:0] rise_out_q, fall_out_q, pw_out_q;
  logic [NUM_CH*CNT_W-1:0]  rcnt_out_q, fcnt_out_q;
  logic                     valid_q, err_q;

  assign shot_edge = i_laser_str & ~laser_q;
  assign publish   = shot_edge & armed_q;
  assign hit_ok    = i_tdc_result_valid_flag & ({1'b0, i_tdc_result_channel_id} < CH_LIMIT);
  // Anything above the published width saturates rather than wrapping.
  assign hit_val   = (|i_tdc_result[TDC_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                                     : i_tdc_result[DATA_W-1:0];

  function automatic logic [DATA_W-1:0] select_val(input logic [1:0]        mode,
                                                    input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] val);
    case (mode)
      2'd1:    select_val = cur;
      2'd2:    select_val = val;
      default: select_val = (val < cur) ? val : cur;
    endcase
  endfunction

  // Laser edge register, timeout counter and armed flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      laser_q  <= 1'b0;
      to_cnt_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      laser_q <= i_laser_str;
      if (shot_edge) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (shot_edge) begin
        armed_q <= 1'b1;
      end else if (to_cnt_q == TO_MAX) begin
        armed_q <= 1'b0;
      end
    end
  end

  // Per-channel accumulator next state; a hit on the edge cycle starts the new shot
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rise_acc_d[ch] = shot_edge ? '0 : rise_acc_q[ch];
      fall_acc_d[ch] = shot_edge ? '0 : fall_acc_q[ch];
      rise_cnt_d[ch] = shot_edge ? '0 : rise_cnt_q[ch];
      fall_cnt_d[ch] = shot_edge ? '0 : fall_cnt_q[ch];
      if (hit_ok && (i_tdc_result_channel_id == CH_ID_W'(ch))) begin
        if (i_tdc_result_edge_id) begin
          rise_acc_d[ch] = (rise_cnt_d[ch] == '0) ? hit_val
                                                  : select_val(i_sel_mode, rise_acc_d[ch], hit_val);
          if (rise_cnt_d[ch] != CNT_MAX) rise_cnt_d[ch] = rise_cnt_d[ch] + CNT_W'(1);
        end else begin
          fall_acc_d[ch] = (fall_cnt_d[ch] == '0) ? hit_val
                                                  : select_val(i_sel_mode, fall_acc_d[ch], hit_val);
          if (fall_cnt_d[ch] != CNT_MAX) fall_cnt_d[ch] = fall_cnt_d[ch] + CNT_W'(1);
        end
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rise_acc_q[ch] <= '0;
        fall_acc_q[ch] <= '0;
        rise_cnt_q[ch] <= '0;
        fall_cnt_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rise_acc_q[ch] <= rise_acc_d[ch];
        fall_acc_q[ch] <= fall_acc_d[ch];
        rise_cnt_q[ch] <= rise_cnt_d[ch];
        fall_cnt_q[ch] <= fall_cnt_d[ch];
      end
    end
  end

  // Snapshot of the finished shot taken on the edge cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        snap_rise_q[ch] <= '0;
        snap_fall_q[ch] <= '0;
        snap_rcnt_q[ch] <= '0;
        snap_fcnt_q[ch] <= '0;
      end
    end else begin
      pend_q <= publish;
      if (publish) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          snap_rise_q[ch] <= (rise_cnt_q[ch] != '0) ? rise_acc_q[ch] : '0;
          snap_fall_q[ch] <= (fall_cnt_q[ch] != '0) ? fall_acc_q[ch] : '0;
          snap_rcnt_q[ch] <= rise_cnt_q[ch];
          snap_fcnt_q[ch] <= fall_cnt_q[ch];
        end
      end
    end
  end

  // Pulse width and error check on the values about to be published
  always_comb begin
    err_any = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pw_next[ch] = '0;
      if ((snap_rcnt_q[ch] != '0) && (snap_fcnt_q[ch] != '0) &&
          (snap_fall_q[ch] >= snap_rise_q[ch])) begin
        pw_next[ch] = snap_fall_q[ch] - snap_rise_q[ch];
      end
      if ((snap_rise_q[ch] > ERR_LIM) || (snap_fall_q[ch] > ERR_LIM)) err_any = 1'b1;
    end
  end

  // Published output registers; data holds between publishes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rise_out_q <= '0;
      fall_out_q <= '0;
      pw_out_q   <= '0;
      rcnt_out_q <= '0;
      fcnt_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= pend_q;
      err_q   <= pend_q & err_any;
      if (pend_q) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          rise_out_q[ch*DATA_W +: DATA_W] <= snap_rise_q[ch];
          fall_out_q[ch*DATA_W +: DATA_W] <= snap_fall_q[ch];
          pw_out_q[ch*DATA_W +: DATA_W]   <= pw_next[ch];
          rcnt_out_q[ch*CNT_W +: CNT_W]   <= snap_rcnt_q[ch];
          fcnt_out_q[ch*CNT_W +: CNT_W]   <= snap_fcnt_q[ch];
        end
      end
    end
  end

  assign o_rise_data   = rise_out_q;
  assign o_fall_data   = fall_out_q;
  assign o_pulse_width = pw_out_q;
  assign o_rise_cnt    = rcnt_out_q;
  assign o_fall_cnt    = fcnt_out_q;
  assign o_data_valid  = valid_q;
  assign o_err_flag    = err_q;
  assign o_armed       = armed_q;

endmodule

// File: tb/tb_tdc_multi_echo_capture.sv
// Bench for tdc_multi_echo_capture: table of single-shot vectors plus corner-case sequences.
module tb_tdc_multi_echo_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        laser;
  logic [1:0]  mode;
  logic        edge_id;
  logic [2:0]  ch_id;
  logic        valid;
  logic [18:0] result;
  logic [63:0] rise_data, fall_data, pulse_width;
  logic [15:0] rise_cnt, fall_cnt;
  logic        data_valid, err_flag, armed;

  int total = 0;
  int bad   = 0;

  // Captured per shot: valid at +1, +2 (publish) and +3 clocks after the laser rise
  logic        v1, v2, v3, e2, e3;
  logic [63:0] cap_rise, cap_fall, cap_pw, hold_rise;
  logic [15:0] cap_rc, cap_fc;

  tdc_multi_echo_capture #(
    .NUM_CH(4), .CH_ID_W(3), .TDC_W(19), .DATA_W(16), .CNT_W(4),
    .TIMEOUT(100), .ERR_LIMIT(2000)
  ) dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_laser_str            (laser),
    .i_sel_mode             (mode),
    .i_tdc_result_edge_id   (edge_id),
    .i_tdc_result_channel_id(ch_id),
    .i_tdc_result_valid_flag(valid),
    .i_tdc_result           (result),
    .o_rise_data            (rise_data),
    .o_fall_data            (fall_data),
    .o_pulse_width          (pulse_width),
    .o_rise_cnt             (rise_cnt),
    .o_fall_cnt             (fall_cnt),
    .o_data_valid           (data_valid),
    .o_err_flag             (err_flag),
    .o_armed                (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [1:0]  md;
    int          nr;
    logic [18:0] r0, r1, r2;
    int          nf;
    logic [18:0] f0, f1;
    logic [15:0] er, ef, ep;
    logic [3:0]  erc, efc;
    logic        ee;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic hit(input logic e, input int c, input logic [18:0] val);
    valid   = 1'b1;
    edge_id = e;
    ch_id   = 3'(c);
    result  = val;
    tick();
    valid   = 1'b0;
  endtask

  // Laser pulse of one cycle, optionally with a hit in the same cycle as the rise
  task automatic do_shot(input bit co, input logic co_e, input int co_ch, input logic [18:0] co_v);
    laser = 1'b1;
    if (co) begin
      valid   = 1'b1;
      edge_id = co_e;
      ch_id   = 3'(co_ch);
      result  = co_v;
    end
    tick();
    valid = 1'b0;
    laser = 1'b0;
    v1 = data_valid;
    tick();
    v2 = data_valid;
    e2 = err_flag;
    cap_rise = rise_data;
    cap_fall = fall_data;
    cap_pw   = pulse_width;
    cap_rc   = rise_cnt;
    cap_fc   = fall_cnt;
    tick();
    v3 = data_valid;
    e3 = err_flag;
    hold_rise = rise_data;
  endtask

  task automatic check_timing(input string name, input logic exp_valid);
    check({name, " valid@1"}, 64'(v1), 64'd0);
    check({name, " valid@2"}, 64'(v2), 64'(exp_valid));
    check({name, " valid@3"}, 64'(v3), 64'd0);
    check({name, " err@3"}, 64'(e3), 64'd0);
  endtask

  task automatic set_vec(input int i, input int c, input logic [1:0] md,
                         input int nr, input logic [18:0] r0, input logic [18:0] r1,
                         input logic [18:0] r2, input int nf, input logic [18:0] f0,
                         input logic [18:0] f1, input logic [15:0] er, input logic [15:0] ef,
                         input logic [15:0] ep, input logic [3:0] erc, input logic [3:0] efc,
                         input logic ee);
    vecs[i].ch = c;   vecs[i].md = md;
    vecs[i].nr = nr;  vecs[i].r0 = r0; vecs[i].r1 = r1; vecs[i].r2 = r2;
    vecs[i].nf = nf;  vecs[i].f0 = f0; vecs[i].f1 = f1;
    vecs[i].er = er;  vecs[i].ef = ef; vecs[i].ep = ep;
    vecs[i].erc = erc; vecs[i].efc = efc; vecs[i].ee = ee;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_r, exp_f, exp_p;
    logic [15:0] exp_rc, exp_fc;
    string       nm;

    //        idx ch md nr  r0        r1   r2   nf f0    f1   er       ef    ep   erc efc ee
    set_vec(0, 0, 0, 1, 100,      0,   0,   0, 0,    0,   100,     0,    0,   1,  0,  0);
    set_vec(1, 1, 0, 3, 300,      120, 250, 2, 400,  380, 120,     380,  260, 3,  2,  0);
    set_vec(2, 1, 1, 3, 300,      120, 250, 2, 400,  380, 300,     400,  100, 3,  2,  0);
    set_vec(3, 1, 2, 3, 300,      120, 250, 2, 400,  380, 250,     380,  130, 3,  2,  0);
    set_vec(4, 1, 3, 3, 300,      120, 250, 2, 400,  380, 120,     380,  260, 3,  2,  0);
    set_vec(5, 2, 0, 1, 2500,     0,   0,   0, 0,    0,   2500,    0,    0,   1,  0,  1);
    set_vec(6, 3, 0, 1, 19'h12345, 0,  0,   0, 0,    0,   16'hFFFF, 0,   0,   1,  0,  1);
    set_vec(7, 3, 0, 1, 700,      0,   0,   1, 500,  0,   700,     500,  0,   1,  1,  0);
    set_vec(8, 2, 0, 1, 2000,     0,   0,   1, 2000, 0,   2000,    2000, 0,   1,  1,  0);
    set_vec(9, 0, 1, 2, 19'h0FFFF, 5,  0,   0, 0,    0,   16'hFFFF, 0,   0,   2,  0,  1);

    rst_n = 1'b0; laser = 1'b0; mode = 2'd0; edge_id = 1'b0;
    ch_id = 3'd0; valid = 1'b0; result = '0;
    tick(); tick(); tick();
    check("reset rise", rise_data, 64'd0);
    check("reset fall", fall_data, 64'd0);
    check("reset pw", pulse_width, 64'd0);
    check("reset cnts", {32'd0, rise_cnt, fall_cnt}, 64'd0);
    check("reset valid/err/armed", {61'd0, data_valid, err_flag, armed}, 64'd0);
    rst_n = 1'b1;
    tick();

    // First edge after reset only arms
    do_shot(0, 1'b0, 0, '0);
    check_timing("arm", 1'b0);
    check("arm armed", 64'(armed), 64'd1);

    for (int i = 0; i < 10; i++) begin
      mode = vecs[i].md;
      if (vecs[i].nr > 0) hit(1'b1, vecs[i].ch, vecs[i].r0);
      if (vecs[i].nr > 1) hit(1'b1, vecs[i].ch, vecs[i].r1);
      if (vecs[i].nr > 2) hit(1'b1, vecs[i].ch, vecs[i].r2);
      if (vecs[i].nf > 0) hit(1'b0, vecs[i].ch, vecs[i].f0);
      if (vecs[i].nf > 1) hit(1'b0, vecs[i].ch, vecs[i].f1);
      do_shot(0, 1'b0, 0, '0);
      exp_r  = {48'd0, vecs[i].er} << (vecs[i].ch * 16);
      exp_f  = {48'd0, vecs[i].ef} << (vecs[i].ch * 16);
      exp_p  = {48'd0, vecs[i].ep} << (vecs[i].ch * 16);
      exp_rc = {12'd0, vecs[i].erc} << (vecs[i].ch * 4);
      exp_fc = {12'd0, vecs[i].efc} << (vecs[i].ch * 4);
      nm = $sformatf("vec%0d", i);
      check_timing(nm, 1'b1);
      check({nm, " rise"}, cap_rise, exp_r);
      check({nm, " fall"}, cap_fall, exp_f);
      check({nm, " pw"}, cap_pw, exp_p);
      check({nm, " rise_cnt"}, 64'(cap_rc), 64'(exp_rc));
      check({nm, " fall_cnt"}, 64'(cap_fc), 64'(exp_fc));
      check({nm, " err"}, 64'(e2), 64'(vecs[i].ee));
      check({nm, " rise hold"}, hold_rise, exp_r);
    end

    // Out-of-range channel ids are ignored
    mode = 2'd0;
    hit(1'b1, 5, 77);
    hit(1'b0, 4, 88);
    do_shot(0, 1'b0, 0, '0);
    check_timing("badch", 1'b1);
    check("badch cnts", {32'd0, cap_rc, cap_fc}, 64'd0);
    check("badch rise", cap_rise, 64'd0);
    check("badch fall", cap_fall, 64'd0);

    // Counter saturation; min selection keeps working once saturated
    mode = 2'd0;
    for (int i = 0; i < 16; i++) hit(1'b1, 0, 50);
    hit(1'b1, 0, 7);
    do_shot(0, 1'b0, 0, '0);
    check("sat0 rise_cnt", 64'(cap_rc), 64'h000F);
    check("sat0 rise", cap_rise, 64'd7);

    // Replace selection after saturation
    mode = 2'd2;
    for (int i = 0; i < 17; i++) hit(1'b1, 0, 19'(i + 1));
    do_shot(0, 1'b0, 0, '0);
    check("sat2 rise_cnt", 64'(cap_rc), 64'h000F);
    check("sat2 rise", cap_rise, 64'd17);

    // Hit coincident with the edge goes to the new shot
    mode = 2'd0;
    hit(1'b1, 1, 40);
    do_shot(1, 1'b1, 1, 55);
    check("coinc rise", cap_rise, 64'd40 << 16);
    check("coinc rise_cnt", 64'(cap_rc), 64'h0010);
    do_shot(0, 1'b0, 0, '0);
    check("coinc next rise", cap_rise, 64'd55 << 16);
    check("coinc next rise_cnt", 64'(cap_rc), 64'h0010);

    // Timeout disarms; the following edge only re-arms
    for (int i = 0; i < 93; i++) tick();
    check("timeout still armed", 64'(armed), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    check("timeout disarmed", 64'(armed), 64'd0);
    hit(1'b1, 0, 9);
    do_shot(0, 1'b0, 0, '0);
    check_timing("rearm", 1'b0);
    check("rearm armed", 64'(armed), 64'd1);
    hit(1'b1, 0, 11);
    do_shot(0, 1'b0, 0, '0);
    check_timing("post-rearm", 1'b1);
    check("post-rearm rise", cap_rise, 64'd11);
    check("post-rearm rise_cnt", 64'(cap_rc), 64'h0001);

    // Reset in the middle of a shot discards it
    hit(1'b1, 2, 123);
    rst_n = 1'b0;
    tick();
    check("midrst rise", rise_data, 64'd0);
    check("midrst cnts", {32'd0, rise_cnt, fall_cnt}, 64'd0);
    check("midrst valid/err/armed", {61'd0, data_valid, err_flag, armed}, 64'd0);
    rst_n = 1'b1;
    tick();
    do_shot(0, 1'b0, 0, '0);
    check_timing("midrst arm", 1'b0);
    do_shot(0, 1'b0, 0, '0);
    check_timing("midrst empty", 1'b1);
    check("midrst empty cnts", {32'd0, cap_rc, cap_fc}, 64'd0);
    check("midrst empty rise", cap_rise, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
